if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage feeding the IF/ID pipeline register. Owns the program counter and drives a single-outstanding-request instruction-memory handshake. Presents `{instruction, pc, pc+4}` to IF/ID, holds them while the hazard unit stalls, and redirects to the EX-stage branch target on `NextPCSrc_in`. Discards any in-flight fetch that a redirect makes stale.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `BUBBLE`, default 32'h0000_0000: instruction word presented when nothing is valid; matches the IF/ID flush value.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `NextPCSrc_in`  in  1  taken branch/jump from EX; redirect fetch.
- `branch_target_in`  in  32  redirect address; bits [1:0] ignored (treated as 0).
- `hazard_detection`  in  1  stall from the hazard unit; IF/ID does not capture while high.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; stable while `imem_req` is high until `imem_ack`.
- `imem_ack`  in  1  read data valid this cycle; may arrive in the same cycle as `imem_req`.
- `imem_rdata`  in  32  instruction word, sampled only when `imem_ack` is high.
- `instruction_out`  out  32  instruction to IF/ID.
- `pc_out_out`  out  32  address of `instruction_out`.
- `sum_out_out`  out  32  `pc_out_out + 4`.
- `fetch_valid`  out  1  outputs hold a real instruction.

## Operation
- Internal registers: `pc` (next address to fetch), `req_addr` (address of the outstanding request), state.
- Reset values: state IDLE, `pc`=RESET_PC, `imem_req`=0, `imem_addr`=RESET_PC, `instruction_out`=BUBBLE, `pc_out_out`=0, `sum_out_out`=0, `fetch_valid`=0.
- **IDLE**: `imem_req`=0; `imem_ack` is ignored. The first clock edge after reset release moves to WAIT, latching `req_addr`=`pc`.
- **WAIT**: `imem_req`=1, `imem_addr`=`req_addr`.
  - Redirect with ack: discard data; `pc`/`req_addr`=target; stay in WAIT.
  - Redirect without ack: `pc`=target; go to DROP.
  - Ack without redirect: `instruction_out`=`imem_rdata`, `pc_out_out`=`req_addr`, `sum_out_out`=`req_addr+4`, `fetch_valid`=1, `pc`=`req_addr+4`; go to PRESENT.
- **PRESENT**: `imem_req`=0; outputs held.
  - Redirect: outputs go to the bubble values with `fetch_valid`=0; `pc`/`req_addr`=target; go to WAIT.
  - Else if `hazard_detection`=0 (consumed): outputs go to the bubble values with `fetch_valid`=0; `req_addr`=`pc`; go to WAIT.
  - Else hold.
- **DROP**: `imem_req`=1 at the stale `req_addr` (the request is never withdrawn).
  - A further redirect overwrites `pc`.
  - On ack: discard data; `req_addr`=`pc`; go to WAIT.
- Priority: redirect > stall > consume.
- Bubble values: `instruction_out`=BUBBLE, `pc_out_out`=0, `sum_out_out`=0.
- Arithmetic: 32-bit, modulo 2^32. 32'hFFFF_FFFC+4 = 32'h0000_0000.
- Asynchronous reset mid-request: all registers return to reset values immediately. A late ack is ignored in IDLE.

## Timing
- Fetch latency: `imem_ack` at edge N makes outputs valid after edge N (visible in cycle N+1).
- With same-cycle ack and no stalls, throughput is one instruction every 2 cycles (WAIT, PRESENT).
- Redirect-to-request: `imem_addr`=target is driven in the cycle after `NextPCSrc_in`, unless a stale request is outstanding (DROP).
- Outputs never change during PRESENT while `hazard_detection`=1 and `NextPCSrc_in`=0.
- `imem_req`/`imem_addr` are registered-state decodes; there is no combinational path from `imem_ack` to `imem_req`.

## Structure
- Shared package `riscv_pkg`:
  - fetch state enum {IDLE, WAIT, PRESENT, DROP};
  - `XLEN`=32;
  - `PC_INC`=4;
  - `BUBBLE` default constant (shared with the IF/ID flush value).
- One sub-module, `if_pc_reg`: `pc` register, `+4` incrementer, target select with [1:0] masking. FSM and output registers stay in `if_fetch`.

## Test plan
- Reset release, `imem_ack` tied to `imem_req`, no stalls:
  - `imem_addr` sequence 0,4,8,…;
  - `fetch_valid` high every other cycle;
  - `pc_out_out`/`sum_out_out` = 0/4, 4/8, ….
- Stall: `hazard_detection`=1 for 5 cycles while presenting pc=8 → outputs frozen at {rdata, 8, 12}; no request issued; next request is 12 after release.
- Redirect during PRESENT (target 0x100) → next cycle bubble with `fetch_valid`=0, `imem_addr`=0x100.
- Redirect while ack is delayed 3 cycles (request at 0x20, target 0x200): `imem_addr` stays 0x20 until ack, data discarded, then request 0x200.
- Two redirects in DROP (0x300 then 0x400) → after the stale ack, fetch 0x400 only; simultaneous redirect+stall in PRESENT → redirect wins.
- Wrap and misalignment:
  - fetch at 0xFFFF_FFFC → `sum_out_out`=0, next fetch 0x0;
  - target 0x103 → fetch 0x100;
  - `rst_n` low mid-WAIT → all outputs at reset values the same cycle, late ack ignored.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types and constants: fetch FSM encoding, datapath
// width, PC increment and the IF/ID flush word.
package riscv_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] PC_INC = 32'd4;
   localparam logic [XLEN-1:0] NOP_BUBBLE = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      PRESENT = 2'd2,
      DROP    = 2'd3
   } fetch_state_e;

   // Instruction addresses are word aligned; low bits of any target are dropped.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return {a[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Program counter register with +4 incrementer and aligned redirect select.
// pc_next is exported so the fetch FSM can latch the same value pc will take.
module if_pc_reg
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect,
   input  logic [XLEN-1:0] target,
   input  logic            advance,
   input  logic [XLEN-1:0] base,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_next,
   output logic [XLEN-1:0] base_inc
);

   assign base_inc = base + PC_INC;

   always_comb begin
      pc_next = pc;
      if (redirect)
         pc_next = word_align(target);
      else if (advance)
         pc_next = base_inc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pc <= RESET_PC;
      else
         pc <= pc_next;
   end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: single-outstanding imem request, IF/ID output
// registers with stall hold, and branch redirect with stale-fetch discard.
module if_fetch
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [XLEN-1:0] BUBBLE   = NOP_BUBBLE
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            NextPCSrc_in,
   input  logic [XLEN-1:0] branch_target_in,
   input  logic            hazard_detection,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] instruction_out,
   output logic [XLEN-1:0] pc_out_out,
   output logic [XLEN-1:0] sum_out_out,
   output logic            fetch_valid
);

   fetch_state_e    state;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_next;
   logic [XLEN-1:0] req_inc;
   logic            redirect;
   logic            advance;

   // Redirects are meaningless before the first fetch has been launched.
   assign redirect = NextPCSrc_in && (state != IDLE);
   assign advance  = (state == WAIT) && imem_ack && !NextPCSrc_in;

   // Pure state decodes: no path from imem_ack back to the request.
   assign imem_req  = (state == WAIT) || (state == DROP);
   assign imem_addr = req_addr;

   if_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
      .clk      (clk),
      .rst_n    (rst_n),
      .redirect (redirect),
      .target   (branch_target_in),
      .advance  (advance),
      .base     (req_addr),
      .pc       (pc),
      .pc_next  (pc_next),
      .base_inc (req_inc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         req_addr        <= RESET_PC;
         instruction_out <= BUBBLE;
         pc_out_out      <= '0;
         sum_out_out     <= '0;
         fetch_valid     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               req_addr <= pc;
               state    <= WAIT;
            end
            WAIT: begin
               if (NextPCSrc_in && imem_ack) begin
                  req_addr <= pc_next;
               end else if (NextPCSrc_in) begin
                  state <= DROP;
               end else if (imem_ack) begin
                  instruction_out <= imem_rdata;
                  pc_out_out      <= req_addr;
                  sum_out_out     <= req_inc;
                  fetch_valid     <= 1'b1;
                  state           <= PRESENT;
               end
            end
            PRESENT: begin
               // Redirect and consume both flush IF/ID; pc_next already
               // holds either the aligned target or the sequential pc.
               if (NextPCSrc_in || !hazard_detection) begin
                  instruction_out <= BUBBLE;
                  pc_out_out      <= '0;
                  sum_out_out     <= '0;
                  fetch_valid     <= 1'b0;
                  req_addr        <= pc_next;
                  state           <= WAIT;
               end
            end
            DROP: begin
               // Stale request stays on the bus until memory answers it.
               if (imem_ack) begin
                  req_addr <= pc_next;
                  state    <= WAIT;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed vector table, ack-tied streaming, random
// traffic against a transaction-level fetch model, and async reset.
module tb_if_fetch;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        NextPCSrc_in = 1'b0;
   logic [31:0] branch_target_in = '0;
   logic        hazard_detection = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] instruction_out;
   logic [31:0] pc_out_out;
   logic [31:0] sum_out_out;
   logic        fetch_valid;

   int checks = 0;
   int errors = 0;

   if_fetch dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .NextPCSrc_in     (NextPCSrc_in),
      .branch_target_in (branch_target_in),
      .hazard_detection (hazard_detection),
      .imem_req         (imem_req),
      .imem_addr        (imem_addr),
      .imem_ack         (imem_ack),
      .imem_rdata       (imem_rdata),
      .instruction_out  (instruction_out),
      .pc_out_out       (pc_out_out),
      .sum_out_out      (sum_out_out),
      .fetch_valid      (fetch_valid)
   );

   always #5 clk = ~clk;

   // Model: fetch launched yet, request on the bus, that request is stale,
   // an instruction is being held for IF/ID, plus the architectural values.
   bit          m_started, m_busy, m_stale, m_hold;
   logic [31:0] m_pc, m_req, m_instr, m_pco, m_sum;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: actual %h required %h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_started = 0; m_busy = 0; m_stale = 0; m_hold = 0;
      m_pc = 32'h0; m_req = 32'h0;
      m_instr = 32'h0; m_pco = 32'h0; m_sum = 32'h0;
   endtask

   task automatic model_bubble();
      m_hold = 0; m_instr = 32'h0; m_pco = 32'h0; m_sum = 32'h0;
   endtask

   task automatic model_step();
      logic [31:0] t;
      t = branch_target_in & 32'hFFFF_FFFC;
      if (!m_started) begin
         m_started = 1; m_busy = 1; m_req = m_pc;
      end else if (m_busy && !m_stale) begin
         if (NextPCSrc_in && imem_ack) begin
            m_pc = t; m_req = t;
         end else if (NextPCSrc_in) begin
            m_pc = t; m_stale = 1;
         end else if (imem_ack) begin
            m_hold = 1; m_instr = imem_rdata; m_pco = m_req; m_sum = m_req + 32'd4;
            m_pc = m_req + 32'd4; m_busy = 0;
         end
      end else if (m_busy) begin
         if (NextPCSrc_in) m_pc = t;
         if (imem_ack) begin
            m_req = m_pc; m_stale = 0;
         end
      end else if (m_hold) begin
         if (NextPCSrc_in) begin
            model_bubble(); m_pc = t; m_req = t; m_busy = 1;
         end else if (!hazard_detection) begin
            model_bubble(); m_req = m_pc; m_busy = 1;
         end
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".req"},   {31'b0, imem_req},    {31'b0, m_busy});
      chk({tag, ".addr"},  imem_addr,            m_req);
      chk({tag, ".valid"}, {31'b0, fetch_valid}, {31'b0, m_hold});
      chk({tag, ".instr"}, instruction_out,      m_instr);
      chk({tag, ".pc"},    pc_out_out,           m_pco);
      chk({tag, ".sum"},   sum_out_out,          m_sum);
   endtask

   // One clock: inputs applied at negedge, model advanced at posedge,
   // outputs compared at the following negedge.
   task automatic cycle(input bit r, input logic [31:0] t, input bit h,
                        input bit a, input logic [31:0] d, input string tag);
      NextPCSrc_in = r; branch_target_in = t; hazard_detection = h;
      imem_ack = a; imem_rdata = d;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_model(tag);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      NextPCSrc_in = 0; hazard_detection = 0; imem_ack = 0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check_model("idle");
   endtask

   typedef struct {
      bit          r;
      logic [31:0] t;
      bit          h;
      bit          a;
      logic [31:0] d;
      bit          e_req;
      logic [31:0] e_addr;
      bit          e_v;
      logic [31:0] e_instr;
      logic [31:0] e_pc;
   } vec_t;

   function automatic vec_t V(bit r, logic [31:0] t, bit h, bit a, logic [31:0] d,
                              bit e_req, logic [31:0] e_addr, bit e_v,
                              logic [31:0] e_instr, logic [31:0] e_pc);
      vec_t v;
      v.r = r; v.t = t; v.h = h; v.a = a; v.d = d;
      v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v;
      v.e_instr = e_instr; v.e_pc = e_pc;
      return v;
   endfunction

   vec_t tbl[$];

   initial begin
      // Directed sequence from reset; each row: inputs before an edge,
      // expected outputs after it.
      tbl.push_back(V(0, 0, 0, 0, 0,            1, 32'h0,   0, 0, 0));
      tbl.push_back(V(0, 0, 0, 1, 32'h1111_0001, 0, 32'h0, 1, 32'h1111_0001, 32'h0));
      tbl.push_back(V(0, 0, 0, 0, 0,            1, 32'h4,   0, 0, 0));
      tbl.push_back(V(0, 0, 0, 1, 32'h1111_0002, 0, 32'h4, 1, 32'h1111_0002, 32'h4));
      tbl.push_back(V(0, 0, 0, 0, 0,            1, 32'h8,   0, 0, 0));
      tbl.push_back(V(0, 0, 1, 1, 32'h1111_0003, 0, 32'h8, 1, 32'h1111_0003, 32'h8));
      for (int i = 0; i < 5; i++)   // stall at pc=8, stray ack must be ignored
         tbl.push_back(V(0, 0, 1, 1, 32'hDEAD_BEEF, 0, 32'h8, 1, 32'h1111_0003, 32'h8));
      tbl.push_back(V(0, 0, 0, 0, 0,            1, 32'hC,   0, 0, 0));
      tbl.push_back(V(0, 0, 0, 1, 32'h1111_0004, 0, 32'hC, 1, 32'h1111_0004, 32'hC));
      tbl.push_back(V(1, 32'h103, 1, 0, 0,      1, 32'h100, 0, 0, 0));
      tbl.push_back(V(0, 0, 0, 1, 32'h1111_0005, 0, 32'h100, 1, 32'h1111_0005, 32'h100));
      tbl.push_back(V(0, 0, 0, 0, 0,            1, 32'h104, 0, 0, 0));
      tbl.push_back(V(1, 32'h203, 0, 0, 0,      1, 32'h104, 0, 0, 0));
      tbl.push_back(V(1, 32'h300, 0, 0, 0,      1, 32'h104, 0, 0, 0));
      tbl.push_back(V(1, 32'h400, 0, 0, 0,      1, 32'h104, 0, 0, 0));
      tbl.push_back(V(0, 0, 0, 1, 32'hBAD0_0001, 1, 32'h400, 0, 0, 0));
      tbl.push_back(V(0, 0, 0, 1, 32'h1111_0006, 0, 32'h400, 1, 32'h1111_0006, 32'h400));
      tbl.push_back(V(0, 0, 0, 0, 0,            1, 32'h404, 0, 0, 0));
      tbl.push_back(V(1, 32'h20, 0, 1, 32'hBAD0_0002, 1, 32'h20, 0, 0, 0));
      tbl.push_back(V(0, 0, 0, 0, 0,            1, 32'h20,  0, 0, 0));
      tbl.push_back(V(1, 32'h200, 0, 0, 0,      1, 32'h20,  0, 0, 0));
      tbl.push_back(V(0, 0, 0, 0, 0,            1, 32'h20,  0, 0, 0));
      tbl.push_back(V(0, 0, 0, 0, 0,            1, 32'h20,  0, 0, 0));
      tbl.push_back(V(0, 0, 0, 1, 32'hBAD0_0003, 1, 32'h200, 0, 0, 0));
      tbl.push_back(V(0, 0, 0, 1, 32'h1111_0007, 0, 32'h200, 1, 32'h1111_0007, 32'h200));
      tbl.push_back(V(1, 32'hFFFF_FFFE, 1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0));
      tbl.push_back(V(0, 0, 0, 1, 32'h1111_0008, 0, 32'hFFFF_FFFC, 1, 32'h1111_0008, 32'hFFFF_FFFC));
      tbl.push_back(V(0, 0, 0, 0, 0,            1, 32'h0,   0, 0, 0));
      tbl.push_back(V(0, 0, 0, 1, 32'h1111_0009, 0, 32'h0, 1, 32'h1111_0009, 32'h0));

      do_reset();
      chk("rst.req",   {31'b0, imem_req},    32'h0);
      chk("rst.addr",  imem_addr,            32'h0);
      chk("rst.valid", {31'b0, fetch_valid}, 32'h0);
      chk("rst.instr", instruction_out,      32'h0);

      foreach (tbl[i]) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         cycle(tbl[i].r, tbl[i].t, tbl[i].h, tbl[i].a, tbl[i].d, "mdl");
         chk({tag, ".req"},   {31'b0, imem_req},    {31'b0, tbl[i].e_req});
         chk({tag, ".addr"},  imem_addr,            tbl[i].e_addr);
         chk({tag, ".valid"}, {31'b0, fetch_valid}, {31'b0, tbl[i].e_v});
         chk({tag, ".instr"}, instruction_out,      tbl[i].e_v ? tbl[i].e_instr : 32'h0);
         chk({tag, ".pc"},    pc_out_out,           tbl[i].e_v ? tbl[i].e_pc : 32'h0);
         chk({tag, ".sum"},   sum_out_out,          tbl[i].e_v ? tbl[i].e_pc + 32'd4 : 32'h0);
      end

      // Ack tied to req, no stalls: one instruction every two cycles.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         cycle(0, 0, 0, imem_req, 32'hA000_0000 + i, "tie");
         chk("tie.valid", {31'b0, fetch_valid}, {31'b0, (i % 2) == 1});
         if (i % 2 == 1) begin
            chk("tie.pc",  pc_out_out,  32'(4 * (i / 2)));
            chk("tie.sum", sum_out_out, 32'(4 * (i / 2) + 4));
         end else begin
            chk("tie.addr", imem_addr, 32'(4 * (i / 2)));
         end
      end

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 3000; i++)
         cycle(($urandom % 8) == 0, $urandom, ($urandom % 3) == 0,
               ($urandom % 2) == 1, $urandom, "rnd");

      // Asynchronous reset while a request is outstanding, then a late ack.
      do_reset();
      cycle(0, 0, 0, 1, 32'h1234_5678, "ar0");
      cycle(0, 0, 0, 1, 32'h1234_5678, "ar1");
      cycle(0, 0, 0, 0, 0, "ar2");
      chk("ar.wait_addr", imem_addr, 32'h4);
      #2;
      rst_n = 1'b0;
      imem_ack = 1'b1;
      #1;
      model_reset();
      chk("ar.req",   {31'b0, imem_req},    32'h0);
      chk("ar.addr",  imem_addr,            32'h0);
      chk("ar.valid", {31'b0, fetch_valid}, 32'h0);
      chk("ar.instr", instruction_out,      32'h0);
      chk("ar.pc",    pc_out_out,           32'h0);
      chk("ar.sum",   sum_out_out,          32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      cycle(0, 0, 0, 1, 32'hBAD0_0004, "late");
      chk("late.valid", {31'b0, fetch_valid}, 32'h0);
      chk("late.addr",  imem_addr,            32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
